// File: rtl/miriscv_mem_arbiter.sv
// Shares one memory bus between fetch and LSU; one outstanding transaction, data priority with starvation limit.
// Latency: grant and response both 0 cycles; requesters are held off by staying unserved (no ready), bus by mem_rvalid_i.
module miriscv_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned XLEN         = 32
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic              instr_req_i,
   input  logic [XLEN-1:0]   instr_addr_i,
   output logic              instr_rvalid_o,
   output logic [XLEN-1:0]   instr_rdata_o,
   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [XLEN/8-1:0] data_be_i,
   input  logic [XLEN-1:0]   data_addr_i,
   input  logic [XLEN-1:0]   data_wdata_i,
   output logic              data_rvalid_o,
   output logic [XLEN-1:0]   data_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_rvalid_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   output logic              busy_o
);

   typedef struct packed {
      logic              we;
      logic [XLEN/8-1:0] be;
      logic [XLEN-1:0]   addr;
      logic [XLEN-1:0]   wdata;
   } req_t;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DRAIN} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state_q, state_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   req_t       pl_q, pl_d;
   req_t       instr_pl, data_pl, mem_pl;
   logic       grant_d, grant_i;

   always_comb begin
      instr_pl       = '0;
      instr_pl.be    = '1;
      instr_pl.addr  = instr_addr_i;
      data_pl.we     = data_we_i;
      data_pl.be     = data_be_i;
      data_pl.addr   = data_addr_i;
      data_pl.wdata  = data_wdata_i;
   end

   always_comb begin
      state_d        = state_q;
      starve_cnt_d   = starve_cnt_q;
      pl_d           = pl_q;
      mem_pl         = pl_q;
      mem_req_o      = 1'b0;
      instr_rvalid_o = 1'b0;
      data_rvalid_o  = 1'b0;
      grant_d        = 1'b0;
      grant_i        = 1'b0;
      case (state_q)
         IDLE: begin
            // Data wins a collision until the fetch has been passed over LIMIT times.
            grant_d = data_req_i && !(instr_req_i && (starve_cnt_q == LIMIT));
            grant_i = instr_req_i && !grant_d;
            if (grant_d) begin
               mem_req_o = 1'b1;
               mem_pl    = data_pl;
               pl_d      = data_pl;
               state_d   = BUSY_D;
               if (!instr_req_i)
                  starve_cnt_d = '0;
               else if (starve_cnt_q != LIMIT)
                  starve_cnt_d = starve_cnt_q + 4'd1;
            end else if (grant_i) begin
               mem_req_o    = 1'b1;
               mem_pl       = instr_pl;
               pl_d         = instr_pl;
               state_d      = BUSY_I;
               starve_cnt_d = '0;
            end
         end
         BUSY_I: begin
            mem_req_o = 1'b1;
            if (mem_rvalid_i) begin
               instr_rvalid_o = 1'b1;
               state_d        = IDLE;
            end else if (!instr_req_i) begin
               state_d = DRAIN;
            end
         end
         BUSY_D: begin
            mem_req_o = 1'b1;
            if (mem_rvalid_i) begin
               data_rvalid_o = 1'b1;
               state_d       = IDLE;
            end
         end
         DRAIN: begin
            // Killed fetch still owns the bus until its response is swallowed.
            mem_req_o = 1'b1;
            if (mem_rvalid_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!arstn_i) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         pl_q         <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         pl_q         <= pl_d;
      end
   end

   assign mem_we_o      = mem_pl.we;
   assign mem_be_o      = mem_pl.be;
   assign mem_addr_o    = mem_pl.addr;
   assign mem_wdata_o   = mem_pl.wdata;
   assign instr_rdata_o = mem_rdata_i;
   assign data_rdata_o  = mem_rdata_i;
   assign busy_o        = (state_q != IDLE);

   a_data_held: assert property (@(posedge clk_i) disable iff (!arstn_i)
      (state_q == BUSY_D) |-> data_req_i);

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench for miriscv_mem_arbiter: inputs driven 1 time unit after posedge,
// outputs compared 1 unit later, well before the next edge.
module tb_miriscv_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   miriscv_mem_arbiter #(.STARVE_LIMIT(4), .XLEN(32)) dut (
      .clk_i(clk_i), .arstn_i(arstn_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      arstn_i = 1'b0; instr_req_i = 1'b0; instr_addr_i = '0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0;
      data_addr_i = '0; data_wdata_i = '0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      step(); step();
      arstn_i = 1'b1;
      #1;
      n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
      n_vec++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
      n_vec++; if (dut.starve_cnt_q !== 4'd0) begin n_err++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt_q); end
   endtask

   task automatic test_single_fetch();
      step();
      instr_req_i = 1'b1; instr_addr_i = 32'h80;
      #1;
      n_vec++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b1_0_1111) begin n_err++; $display("FAIL fetch_grant: got req/we/be %b want 101111", {mem_req_o, mem_we_o, mem_be_o}); end
      n_vec++; if (mem_addr_o !== 32'h80) begin n_err++; $display("FAIL fetch_addr: got %h want 80", mem_addr_o); end
      n_vec++; if (mem_wdata_o !== 32'h0) begin n_err++; $display("FAIL fetch_wdata: got %h want 0", mem_wdata_o); end
      step();
      mem_rvalid_i = 1'b0;
      #1;
      n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL fetch_busy: got %b want 1", busy_o); end
      step(); step();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00000013;
      #1;
      n_vec++; if (instr_rvalid_o !== 1'b1) begin n_err++; $display("FAIL fetch_rvalid: got %b want 1", instr_rvalid_o); end
      n_vec++; if (instr_rdata_o !== 32'h13) begin n_err++; $display("FAIL fetch_rdata: got %h want 00000013", instr_rdata_o); end
      n_vec++; if (data_rvalid_o !== 1'b0) begin n_err++; $display("FAIL fetch_data_rvalid: got %b want 0", data_rvalid_o); end
      step();
      instr_req_i = 1'b0; mem_rvalid_i = 1'b0;
      #1;
      n_vec++; if ({busy_o, mem_req_o, instr_rvalid_o} !== 3'b000) begin n_err++; $display("FAIL fetch_done: got busy/req/rv %b want 000", {busy_o, mem_req_o, instr_rvalid_o}); end
   endtask

   task automatic test_back_to_back();
      step();
      data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h100;
      data_wdata_i = 32'hDEADBEEF; data_be_i = 4'h3;
      instr_req_i = 1'b1; instr_addr_i = 32'h84;
      #1;
      n_vec++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 4'h3, 32'h100, 32'hDEADBEEF}) begin
         n_err++; $display("FAIL coll_data_first: got we %b be %h addr %h wdata %h want 1 3 100 deadbeef", mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
      step(); step();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A0000;
      #1;
      n_vec++; if ({data_rvalid_o, instr_rvalid_o} !== 2'b10) begin n_err++; $display("FAIL coll_data_resp: got d/i %b want 10", {data_rvalid_o, instr_rvalid_o}); end
      step();
      data_req_i = 1'b0; mem_rvalid_i = 1'b0;
      #1;
      n_vec++; if ({busy_o, mem_req_o, mem_we_o, mem_addr_o} !== {1'b0, 1'b1, 1'b0, 32'h84}) begin
         n_err++; $display("FAIL coll_instr_grant: got busy %b req %b we %b addr %h want 0 1 0 84", busy_o, mem_req_o, mem_we_o, mem_addr_o); end
      step();
      mem_rvalid_i = 1'b1;
      #1;
      n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin n_err++; $display("FAIL coll_instr_resp: got i/d %b want 10", {instr_rvalid_o, data_rvalid_o}); end
      step();
      instr_req_i = 1'b0; mem_rvalid_i = 1'b0;
   endtask

   task automatic test_starvation();
      bit exp_instr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] want;
      for (int t = 0; t < 6; t++) begin
         step();
         instr_req_i = 1'b1; instr_addr_i = 32'h300;
         data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h200; data_be_i = 4'hF;
         mem_rvalid_i = 1'b0;
         #1;
         want = exp_instr[t] ? 32'h300 : 32'h200;
         n_vec++; if (mem_addr_o !== want) begin n_err++; $display("FAIL starve_grant%0d: got addr %h want %h", t, mem_addr_o, want); end
         step();
         mem_rvalid_i = 1'b1;
         #1;
         if (t == 3) begin
            n_vec++; if (dut.starve_cnt_q !== 4'd4) begin n_err++; $display("FAIL starve_cnt_sat: got %0d want 4", dut.starve_cnt_q); end
         end
         if (t == 4) begin
            n_vec++; if (dut.starve_cnt_q !== 4'd0) begin n_err++; $display("FAIL starve_cnt_clr: got %0d want 0", dut.starve_cnt_q); end
         end
      end
      step();
      instr_req_i = 1'b0; data_req_i = 1'b0; mem_rvalid_i = 1'b0;
   endtask

   task automatic test_abort();
      step();
      mem_rvalid_i = 1'b1;
      #1;
      n_vec++; if ({instr_rvalid_o, data_rvalid_o, mem_req_o} !== 3'b000) begin n_err++; $display("FAIL idle_rvalid_ignored: got i/d/req %b want 000", {instr_rvalid_o, data_rvalid_o, mem_req_o}); end
      step();
      mem_rvalid_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h400;
      #1;
      n_vec++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL abort_grant: got %b want 1", mem_req_o); end
      step();
      instr_req_i = 1'b0;
      #1;
      n_vec++; if ({instr_rvalid_o, mem_req_o} !== 2'b01) begin n_err++; $display("FAIL abort_drop: got rv/req %b want 01", {instr_rvalid_o, mem_req_o}); end
      step();
      mem_rvalid_i = 1'b1;
      #1;
      n_vec++; if (dut.state_q !== 2'd3) begin n_err++; $display("FAIL abort_state: got %0d want 3 (DRAIN)", dut.state_q); end
      n_vec++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h400}) begin n_err++; $display("FAIL abort_hold: got req %b addr %h want 1 400", mem_req_o, mem_addr_o); end
      n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin n_err++; $display("FAIL abort_discard: got i/d %b want 00", {instr_rvalid_o, data_rvalid_o}); end
      step();
      mem_rvalid_i = 1'b0;
      #1;
      n_vec++; if ({busy_o, mem_req_o} !== 2'b00) begin n_err++; $display("FAIL abort_idle: got busy/req %b want 00", {busy_o, mem_req_o}); end
      // Grant-cycle response ignored, then drop coinciding with response is still delivered.
      step();
      instr_req_i = 1'b1; instr_addr_i = 32'h404; mem_rvalid_i = 1'b1;
      #1;
      n_vec++; if (instr_rvalid_o !== 1'b0) begin n_err++; $display("FAIL grant_cycle_rvalid: got %b want 0", instr_rvalid_o); end
      step();
      instr_req_i = 1'b0; mem_rvalid_i = 1'b1;
      #1;
      n_vec++; if ({busy_o, instr_rvalid_o} !== 2'b11) begin n_err++; $display("FAIL drop_with_resp: got busy/rv %b want 11", {busy_o, instr_rvalid_o}); end
      step();
      mem_rvalid_i = 1'b0;
      #1;
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL drop_with_resp_idle: got %b want 0", busy_o); end
   endtask

   task automatic test_payload_stability();
      step();
      data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h500;
      data_wdata_i = 32'h11112222; data_be_i = 4'hF;
      step();
      data_we_i = 1'b0; data_addr_i = 32'h600; data_wdata_i = 32'h33334444; data_be_i = 4'h1;
      #1;
      n_vec++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 4'hF, 32'h500, 32'h11112222}) begin
         n_err++; $display("FAIL stable_busy: got we %b be %h addr %h wdata %h want 1 f 500 11112222", mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
      step();
      mem_rvalid_i = 1'b1;
      #1;
      n_vec++; if ({data_rvalid_o, mem_addr_o, mem_wdata_o} !== {1'b1, 32'h500, 32'h11112222}) begin
         n_err++; $display("FAIL stable_resp: got rv %b addr %h wdata %h want 1 500 11112222", data_rvalid_o, mem_addr_o, mem_wdata_o); end
      step();
      data_req_i = 1'b0; mem_rvalid_i = 1'b0;
   endtask

   task automatic test_reset_midop();
      step();
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h700; data_be_i = 4'hF;
      step();
      arstn_i = 1'b0;
      #1;
      n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL midop_busy: got %b want 1", busy_o); end
      step();
      arstn_i = 1'b1; data_req_i = 1'b0; mem_rvalid_i = 1'b1;
      #1;
      n_vec++; if ({data_rvalid_o, instr_rvalid_o} !== 2'b00) begin n_err++; $display("FAIL midop_late_resp: got d/i %b want 00", {data_rvalid_o, instr_rvalid_o}); end
      n_vec++; if ({busy_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== 39'h0) begin
         n_err++; $display("FAIL midop_outputs: got busy %b req %b we %b be %h addr %h want all 0", busy_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o); end
      n_vec++; if (dut.state_q !== 2'd0) begin n_err++; $display("FAIL midop_state: got %0d want 0 (IDLE)", dut.state_q); end
      step();
      mem_rvalid_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_starvation();
      test_abort();
      test_payload_stability();
      test_reset_midop();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/miriscv_mem_arbiter.md
# miriscv_mem_arbiter

Two-port to one-port memory arbiter that shares the core's single external memory bus between the instruction-fetch port and the LSU data port. It sits between the fetch unit and decode-stage LSU on one side and the memory/interconnect on the other. It allows one outstanding transaction at a time, gives data requests priority, guarantees instruction progress through a starvation limit, and discards responses belonging to aborted requests.

## Interface
- STARVE_LIMIT, 4, max consecutive data grants while an instr request is pending; legal range 1..15
- XLEN, 32, data/address width
- clk_i  in  1  clock
- arstn_i  in  1  reset; one clock, synchronous, active-low
- instr_req_i  in  1  fetch request; held with stable addr until instr_rvalid_o, may be dropped (fetch kill)
- instr_addr_i  in  XLEN  fetch address
- instr_rvalid_o  out  1  fetch response valid, one cycle
- instr_rdata_o  out  XLEN  fetch read data (= mem_rdata_i)
- data_req_i  in  1  LSU request; held with stable payload until data_rvalid_o
- data_we_i  in  1  LSU write enable
- data_be_i  in  XLEN/8  LSU byte enables
- data_addr_i  in  XLEN  LSU address
- data_wdata_i  in  XLEN  LSU write data
- data_rvalid_o  out  1  LSU response valid, one cycle
- data_rdata_o  out  XLEN  LSU read data (= mem_rdata_i)
- mem_req_o  out  1  bus request, high from grant until mem_rvalid_i
- mem_we_o  out  1  bus write enable (0 for fetch)
- mem_be_o  out  XLEN/8  bus byte enables (all ones for fetch)
- mem_addr_o  out  XLEN  bus address
- mem_wdata_o  out  XLEN  bus write data (0 for fetch)
- mem_rvalid_i  in  1  bus response valid
- mem_rdata_i  in  XLEN  bus read data
- busy_o  out  1  high in any state other than IDLE

## Operation
- States: IDLE, BUSY_I, BUSY_D, DRAIN.
- IDLE: arbitrate combinationally; winner's payload driven on mem_* with mem_req_o=1 in the same cycle; payload latched into internal registers at cycle end; go to BUSY_I/BUSY_D.
- Arbitration: data only -> data; instr only -> instr; both -> data, unless starve_cnt == STARVE_LIMIT, then instr.
- starve_cnt: +1 on a data grant while instr_req_i=1; cleared on any instr grant or a data grant with instr_req_i=0; saturates at STARVE_LIMIT.
- BUSY_x: mem_req_o=1, mem_* from latched registers (independent of requester inputs). On mem_rvalid_i: pulse owner's rvalid_o, go to IDLE.
- Abort: instr_req_i=0 in BUSY_I without mem_rvalid_i -> DRAIN. Simultaneous drop and mem_rvalid_i -> response still delivered (instr_rvalid_o=1), go IDLE.
- DRAIN: mem_req_o=1 (latched payload); on mem_rvalid_i, response discarded (no rvalid_o), go IDLE. Data requests are never aborted; data_req_i drop in BUSY_D is a protocol violation (assertion).
- mem_rvalid_i in IDLE is ignored (no rvalid_o pulse).
- Non-owner's rvalid_o is never asserted.

## Timing
- Reset (arstn_i=0 at posedge): state IDLE, starve_cnt 0, latched payload 0; next cycle mem_req_o 0 unless a requester is high, rvalids 0, busy_o 0. Reset mid-transaction abandons it; a late mem_rvalid_i then lands in IDLE and is ignored.
- Grant latency 0: mem_req_o rises in the cycle the request is seen in IDLE.
- Response latency 0: rvalid_o = mem_rvalid_i in the same cycle (combinational route).
- Back-to-back: rvalid cycle -> IDLE next cycle -> new grant that cycle; min 2 cycles per transaction, 1 idle-state cycle between transactions.
- mem_rvalid_i required no earlier than the cycle after grant; mem_rvalid_i in the grant cycle is ignored.
- rdata outputs are unconditional copies of mem_rdata_i; only rvalids are qualified.

## Test plan
- Single fetch: instr_req_i=1, addr 0x80 in IDLE -> mem_req_o=1, mem_addr_o=0x80, mem_we_o=0, mem_be_o=4'hF same cycle; rvalid after 3 cycles with rdata 0x00000013 -> instr_rvalid_o=1, instr_rdata_o=0x00000013, data_rvalid_o=0.
- Collision: both request in IDLE (data write, addr 0x100, wdata 0xDEADBEEF, be 4'h3) -> data granted first with exact payload; instr granted in the IDLE cycle after data response.
- Starvation: instr held high, data re-requests immediately every transaction, STARVE_LIMIT=4 -> grants D,D,D,D,I,D,...; starve_cnt returns to 0 after the I grant.
- Abort: fetch granted, instr_req_i dropped one cycle later, mem_rvalid_i two cycles later -> state DRAIN, mem_req_o held, no instr_rvalid_o, busy_o low the cycle after.
- Payload stability: in BUSY_D, change data_addr_i/data_wdata_i -> mem_addr_o/mem_wdata_o keep latched values until mem_rvalid_i.
- Reset mid-op: arstn_i=0 in BUSY_D, then mem_rvalid_i after release -> no data_rvalid_o, state IDLE, all outputs at reset values.
